// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_core_p accumulator machine: states, ALU modes,
// instruction fields and decode helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, IMM, MEM, EXEC, HALT, FAULT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR
  } alu_mode_t;

  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] op1;
    logic [2:0] op2;
  } instr_t;

  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_LDI = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [2:0] CTL_JMP  = 3'd0;
  localparam logic [2:0] CTL_JEZ  = 3'd1;
  localparam logic [2:0] CTL_JNZ  = 3'd2;
  localparam logic [2:0] CTL_JC   = 3'd3;
  localparam logic [2:0] CTL_CALL = 3'd4;
  localparam logic [2:0] CTL_RET  = 3'd5;
  localparam logic [2:0] CTL_OUT  = 3'd6;
  localparam logic [2:0] CTL_HALT = 3'd7;

  localparam logic [2:0] REG_MEM = 3'd7;

  // LDI into index 7 is rejected: there is no register there to load.
  function automatic logic instr_valid(input instr_t i);
    logic ok;
    ok = 1'b0;
    case (i.cls)
      CLS_MOV: ok = !((i.op1 == REG_MEM) && (i.op2 == REG_MEM));
      CLS_ALU: ok = (i.op2 == 3'd0);
      CLS_LDI: ok = (i.op1 == 3'd0) && (i.op2 != REG_MEM);
      default: ok = (i.op2 == 3'd0);
    endcase
    return ok;
  endfunction

  function automatic logic needs_imm(input instr_t i);
    logic n;
    n = 1'b0;
    case (i.cls)
      CLS_MOV: n = (i.op1 == REG_MEM) || (i.op2 == REG_MEM);
      CLS_LDI: n = 1'b1;
      CLS_CTL: n = (i.op1 <= CTL_CALL);
      default: n = 1'b0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cpu_alu_p.sv
// Combinational ALU: result modulo 2^DATA_W with carry/borrow/shift-out and zero.
module cpu_alu_p
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_mode_t         mode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (mode)
      ALU_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle accumulator CPU with req/ack memory port, return stack and OUT port.
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_t            state;
  instr_t            ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ir_pc;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] regs [8];
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              z_flag;
  logic              c_flag;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic [ADDR_W-1:0] imm_addr;

  assign imm_addr = imm[ADDR_W-1:0];

  cpu_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (regs[0]),
    .b      (regs[1]),
    .mode   (alu_mode_t'(ir.op1)),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Each memory state raises req once, holds the bus, and completes on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      ir        <= '0;
      pc        <= '0;
      ir_pc     <= '0;
      imm       <= '0;
      sp        <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            ir      <= instr_t'(mem_rdata[7:0]);
            ir_pc   <= pc;
            pc      <= pc + ADDR_W'(1);
            state   <= DECODE;
          end
        end

        DECODE: state <= (instr_valid(ir) && needs_imm(ir)) ? IMM : EXEC;

        IMM: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            imm     <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            state   <= (ir.cls == CLS_MOV) ? MEM : EXEC;
          end
        end

        MEM: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= (ir.op1 == REG_MEM);
            mem_addr  <= imm_addr;
            mem_wdata <= regs[ir.op2];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) regs[ir.op1] <= mem_rdata;
            state <= FETCH;
          end
        end

        EXEC: begin
          state <= FETCH;
          if (!instr_valid(ir)) begin
            state  <= FAULT;
            fault  <= 1'b1;
            halted <= 1'b1;
          end else begin
            case (ir.cls)
              CLS_MOV: regs[ir.op1] <= regs[ir.op2];
              CLS_ALU: begin
                regs[0] <= alu_result;
                z_flag  <= alu_zero;
                c_flag  <= alu_carry;
              end
              CLS_LDI: regs[ir.op2] <= imm;
              default: begin
                case (ir.op1)
                  CTL_JMP: pc <= imm_addr;
                  CTL_JEZ: if (z_flag) pc <= imm_addr;
                  CTL_JNZ: if (!z_flag) pc <= imm_addr;
                  CTL_JC:  if (c_flag) pc <= imm_addr;
                  // Stack faults rewind PC to the offending instruction.
                  CTL_CALL: begin
                    if (sp == SP_W'(STACK_DEPTH)) begin
                      pc     <= ir_pc;
                      state  <= FAULT;
                      fault  <= 1'b1;
                      halted <= 1'b1;
                    end else begin
                      stack[IDX_W'(sp)] <= pc;
                      sp                <= sp + SP_W'(1);
                      pc                <= imm_addr;
                    end
                  end
                  CTL_RET: begin
                    if (sp == '0) begin
                      pc     <= ir_pc;
                      state  <= FAULT;
                      fault  <= 1'b1;
                      halted <= 1'b1;
                    end else begin
                      pc <= stack[IDX_W'(sp - SP_W'(1))];
                      sp <= sp - SP_W'(1);
                    end
                  end
                  CTL_OUT: begin
                    out_data  <= regs[0];
                    out_valid <= 1'b1;
                  end
                  default: begin
                    state  <= HALT;
                    halted <= 1'b1;
                  end
                endcase
              end
            endcase
          end
        end

        default: state <= state;
      endcase
    end
  end

endmodule
